// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot pixel pipeline.
package mandel_pkg;

    localparam int DEF_WORD_LENGTH = 32;
    localparam int DEF_FRAC        = 28;
    localparam int DEF_H_RES       = 640;
    localparam int DEF_V_RES       = 480;

    // Pixel coordinate width; covers resolutions up to 2047.
    localparam int CW = 11;

    // 1.0 in the default Q format.
    localparam logic [DEF_WORD_LENGTH-1:0] ONE = DEF_WORD_LENGTH'(1) << DEF_FRAC;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        OUTPUT    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pixel_scheduler_coord_stepper.sv
// Raster-order coordinate generator: x/y counters plus incrementally
// stepped complex coordinate accumulators and end-of-line/frame flags.
module coord_stepper
    import mandel_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [WORD_LENGTH-1:0] re_min,
    input  logic [WORD_LENGTH-1:0] im_max,
    input  logic [WORD_LENGTH-1:0] step,
    output logic [CW-1:0]          x,
    output logic [CW-1:0]          y,
    output logic [WORD_LENGTH-1:0] re_acc,
    output logic [WORD_LENGTH-1:0] im_acc,
    output logic                   eol,
    output logic                   eof
);

    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);

    logic [CW-1:0]          x_q, x_d;
    logic [CW-1:0]          y_q, y_d;
    logic [WORD_LENGTH-1:0] re_q, re_d;
    logic [WORD_LENGTH-1:0] im_q, im_d;
    logic [WORD_LENGTH-1:0] re_min_sh_q, re_min_sh_d;
    logic [WORD_LENGTH-1:0] step_sh_q, step_sh_d;

    assign eol = (x_q == X_LAST);
    assign eof = eol && (y_q == Y_LAST);

    // Next coordinates: load snapshots config, advance steps one pixel.
    // Shadowed step/re_min keep mid-frame config changes from leaking in.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        re_d        = re_q;
        im_d        = im_q;
        re_min_sh_d = re_min_sh_q;
        step_sh_d   = step_sh_q;
        if (load) begin
            x_d         = '0;
            y_d         = '0;
            re_d        = re_min;
            im_d        = im_max;
            re_min_sh_d = re_min;
            step_sh_d   = step;
        end else if (advance) begin
            if (eol) begin
                x_d  = '0;
                y_d  = y_q + CW'(1);
                re_d = re_min_sh_q;
                im_d = im_q - step_sh_q;
            end else begin
                x_d  = x_q + CW'(1);
                re_d = re_q + step_sh_q;
            end
        end
    end

    // Coordinate state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            re_q        <= '0;
            im_q        <= '0;
            re_min_sh_q <= '0;
            step_sh_q   <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            re_q        <= re_d;
            im_q        <= im_d;
            re_min_sh_q <= re_min_sh_d;
            step_sh_q   <= step_sh_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign re_acc = re_q;
    assign im_acc = im_q;

endmodule

// File: rtl/pixel_scheduler.sv
// Feeds one depth_calculator pixel-by-pixel in raster order and streams
// {x, y, depth} downstream on a valid/ready interface.
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int FRAC        = DEF_FRAC,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_min,
    input  logic [WORD_LENGTH-1:0] im_max,
    input  logic [WORD_LENGTH-1:0] step,
    output logic                   calc_start,
    output logic [10:0]            calc_x,
    output logic [10:0]            calc_y,
    output logic [WORD_LENGTH-1:0] calc_re_c,
    output logic [WORD_LENGTH-1:0] calc_im_c,
    input  logic                   calc_done,
    input  logic [10:0]            calc_depth,
    output logic                   px_valid,
    input  logic                   px_ready,
    output logic [10:0]            px_x,
    output logic [10:0]            px_y,
    output logic [10:0]            px_depth,
    output logic                   px_eol,
    output logic                   px_eof,
    output logic                   busy,
    output logic                   frame_done
);

    if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_bad_frac
        $error("pixel_scheduler: FRAC must lie in [0, WORD_LENGTH)");
    end
    if (H_RES < 1 || H_RES > 2047 || V_RES < 1 || V_RES > 2047) begin : g_bad_res
        $error("pixel_scheduler: H_RES/V_RES must lie in 1..2047");
    end

    sched_state_t state_q;
    logic         calc_start_q;
    logic         px_valid_q;
    logic [10:0]  px_x_q, px_y_q, px_depth_q;
    logic         px_eol_q, px_eof_q;
    logic         busy_q;
    logic         frame_done_q;

    logic         load, advance;
    logic [10:0]  cur_x, cur_y;
    logic         cur_eol, cur_eof;

    // Stepper strobes: snapshot on frame acceptance, step on every
    // non-final handshake (the final one returns to IDLE untouched).
    assign load    = (state_q == IDLE) && frame_start;
    assign advance = (state_q == OUTPUT) && px_ready && !px_eof_q;

    coord_stepper #(
        .WORD_LENGTH(WORD_LENGTH),
        .H_RES      (H_RES),
        .V_RES      (V_RES)
    ) u_stepper (
        .clk    (sysclk),
        .rst    (reset),
        .load   (load),
        .advance(advance),
        .re_min (re_min),
        .im_max (im_max),
        .step   (step),
        .x      (cur_x),
        .y      (cur_y),
        .re_acc (calc_re_c),
        .im_acc (calc_im_c),
        .eol    (cur_eol),
        .eof    (cur_eof)
    );

    // Scheduler FSM; calc_start is raised on every entry into ISSUE so it
    // is high exactly for the ISSUE cycle.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            calc_start_q <= 1'b0;
            px_valid_q   <= 1'b0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_depth_q   <= '0;
            px_eol_q     <= 1'b0;
            px_eof_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            calc_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        calc_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (calc_done) begin
                        px_depth_q <= calc_depth;
                        px_x_q     <= cur_x;
                        px_y_q     <= cur_y;
                        px_eol_q   <= cur_eol;
                        px_eof_q   <= cur_eof;
                        px_valid_q <= 1'b1;
                        state_q    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (px_ready) begin
                        px_valid_q <= 1'b0;
                        if (px_eof_q) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            calc_start_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign calc_start = calc_start_q;
    assign calc_x     = cur_x;
    assign calc_y     = cur_y;
    assign px_valid   = px_valid_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_depth   = px_depth_q;
    assign px_eol     = px_eol_q;
    assign px_eof     = px_eof_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: a 4x3 instance driven through a
// full frame, backpressure, ignored mid-frame config, and reset abort,
// plus a 1x1 instance for the single-pixel corner.
module tb_pixel_scheduler;

    localparam logic [31:0] RE_MIN = 32'hE000_0000;
    localparam logic [31:0] IM_MAX = 32'h1000_0000;
    localparam logic [31:0] STEP   = 32'h0800_0000;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    logic [31:0] re_min = RE_MIN;
    logic [31:0] im_max = IM_MAX;
    logic [31:0] step   = STEP;

    // 4x3 instance signals
    logic        fs0 = 1'b0, cs0, done0, vld0, rdy0 = 1'b1, eol0, eof0, busy0, fd0;
    logic [10:0] cx0, cy0, dep_in0, px0, py0, pd0;
    logic [31:0] re0, im0;
    // 1x1 instance signals
    logic        fs1 = 1'b0, cs1, done1, vld1, rdy1 = 1'b1, eol1, eof1, busy1, fd1;
    logic [10:0] cx1, cy1, dep_in1, px1, py1, pd1;
    logic [31:0] re1, im1;

    pixel_scheduler #(.WORD_LENGTH(32), .FRAC(28), .H_RES(4), .V_RES(3)) dut0 (
        .sysclk(sysclk), .reset(reset), .frame_start(fs0),
        .re_min(re_min), .im_max(im_max), .step(step),
        .calc_start(cs0), .calc_x(cx0), .calc_y(cy0),
        .calc_re_c(re0), .calc_im_c(im0),
        .calc_done(done0), .calc_depth(dep_in0),
        .px_valid(vld0), .px_ready(rdy0), .px_x(px0), .px_y(py0),
        .px_depth(pd0), .px_eol(eol0), .px_eof(eof0),
        .busy(busy0), .frame_done(fd0)
    );

    pixel_scheduler #(.WORD_LENGTH(32), .FRAC(28), .H_RES(1), .V_RES(1)) dut1 (
        .sysclk(sysclk), .reset(reset), .frame_start(fs1),
        .re_min(re_min), .im_max(im_max), .step(step),
        .calc_start(cs1), .calc_x(cx1), .calc_y(cy1),
        .calc_re_c(re1), .calc_im_c(im1),
        .calc_done(done1), .calc_depth(dep_in1),
        .px_valid(vld1), .px_ready(rdy1), .px_x(px1), .px_y(py1),
        .px_depth(pd1), .px_eol(eol1), .px_eof(eof1),
        .busy(busy1), .frame_done(fd1)
    );

    // depth_calculator models: depth = x + 4*y, done a few cycles after start
    logic [2:0] cnt0, cnt1;
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0; done0 <= 1'b0; dep_in0 <= '0;
        end else begin
            done0 <= 1'b0;
            if (cs0) begin
                cnt0 <= 3'd3; dep_in0 <= cx0 + 11'(4) * cy0;
            end else if (cnt0 != 0) begin
                cnt0 <= cnt0 - 3'd1;
                if (cnt0 == 3'd1) done0 <= 1'b1;
            end
        end
    end
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt1 <= '0; done1 <= 1'b0; dep_in1 <= '0;
        end else begin
            done1 <= 1'b0;
            if (cs1) begin
                cnt1 <= 3'd3; dep_in1 <= cx1 + 11'(4) * cy1;
            end else if (cnt1 != 0) begin
                cnt1 <= cnt1 - 3'd1;
                if (cnt1 == 3'd1) done1 <= 1'b1;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt0 = 0;

    // scoreboards: {x, y, re, im} per issue, {x, y, depth, eol, eof} per output
    logic [85:0] q_iss[$];
    logic [34:0] q_out[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame0();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                q_iss.push_back({11'(x), 11'(y), RE_MIN + 32'(x) * STEP, IM_MAX - 32'(y) * STEP});
                q_out.push_back({11'(x), 11'(y), 11'(x + 4 * y), x == 3, (x == 3) && (y == 2)});
            end
    endtask

    task automatic pulse_fs0();
        @(negedge sysclk); fs0 = 1'b1;
        @(negedge sysclk); fs0 = 1'b0;
    endtask

    task automatic wait_cs0(input int wx, input int wy);
        int n;
        n = 0;
        while (!(cs0 && cx0 == 11'(wx) && cy0 == 11'(wy)) && n < 400) begin
            @(negedge sysclk); n++;
        end
        chk($sformatf("reach_issue_%0d_%0d", wx, wy), {cs0, cx0, cy0}, {1'b1, 11'(wx), 11'(wy)});
    endtask

    task automatic wait_fd0();
        int n;
        n = 0;
        while (!fd0 && n < 600) begin
            @(negedge sysclk); n++;
        end
        chk("frame_done_seen", fd0, 1'b1);
        chk("busy_low_at_frame_done", busy0, 1'b0);
    endtask

    // output monitor for the 4x3 instance
    initial begin : mon0
        logic cs_prev, done_prev;
        logic [85:0] ei;
        logic [34:0] eo;
        cs_prev = 1'b0; done_prev = 1'b0;
        forever begin
            @(negedge sysclk);
            if (reset) begin
                cs_prev = 1'b0; done_prev = 1'b0;
            end else begin
                if (done_prev) chk("px_valid_after_done", vld0, 1'b1);
                if (cs0) begin
                    chk("calc_start_single_cycle", cs_prev, 1'b0);
                    chk("issue_queue_nonempty", q_iss.size() != 0, 1'b1);
                    if (q_iss.size() != 0) begin
                        ei = q_iss.pop_front();
                        chk("issue_coords", {cx0, cy0, re0, im0}, ei);
                    end
                end
                if (vld0 && rdy0) begin
                    chk("out_queue_nonempty", q_out.size() != 0, 1'b1);
                    if (q_out.size() != 0) begin
                        eo = q_out.pop_front();
                        chk("px_fields", {px0, py0, pd0, eol0, eof0}, eo);
                    end
                end
                if (fd0) fd_cnt0++;
                cs_prev = cs0; done_prev = done0;
            end
        end
    end

    initial begin : stim
        logic [34:0] held;
        int n;

        // reset state
        repeat (3) @(negedge sysclk);
        chk("reset_outputs0", {cs0, cx0, cy0, re0, im0, vld0, px0, py0, pd0, eol0, eof0, busy0, fd0}, '0);
        chk("reset_outputs1", {cs1, cx1, cy1, re1, im1, vld1, px1, py1, pd1, eol1, eof1, busy1, fd1}, '0);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        // full frame: first issue one cycle after acceptance
        push_frame0();
        pulse_fs0();
        chk("calc_start_after_accept", cs0, 1'b1);
        chk("busy_after_accept", busy0, 1'b1);

        // backpressure at (2,1)
        wait_cs0(2, 1);
        rdy0 = 1'b0;
        n = 0;
        while (!vld0 && n < 50) begin @(negedge sysclk); n++; end
        chk("bp_valid_rises", vld0, 1'b1);
        held = {px0, py0, pd0, eol0, eof0};
        chk("bp_held_pixel", held, {11'd2, 11'd1, 11'd6, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            chk("bp_stable", {vld0, px0, py0, pd0, eol0, eof0, cs0}, {1'b1, held, 1'b0});
        end
        @(posedge sysclk); #1 rdy0 = 1'b1;
        @(negedge sysclk);
        wait_cs0(3, 1);

        // mid-frame frame_start and re_min change are ignored
        wait_cs0(1, 2);
        fs0 = 1'b1; re_min = 32'h0000_0000;
        @(negedge sysclk); fs0 = 1'b0;
        wait_fd0();
        repeat (4) @(negedge sysclk);
        chk("frame_done_once", fd_cnt0, 1);
        chk("queues_drained", {q_iss.size() == 0, q_out.size() == 0}, 2'b11);
        re_min = RE_MIN;

        // reset while waiting on (1,1) aborts the frame
        push_frame0();
        pulse_fs0();
        wait_cs0(1, 1);
        @(negedge sysclk);
        reset = 1'b1;
        #1;
        chk("abort_outputs", {cs0, cx0, cy0, re0, im0, vld0, px0, py0, pd0, eol0, eof0, busy0, fd0}, '0);
        q_iss.delete(); q_out.delete();
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (10) @(negedge sysclk);
        chk("no_frame_done_after_abort", {fd_cnt0, busy0}, {32'd1, 1'b0});
        push_frame0();
        pulse_fs0();
        chk("restart_issue", {cs0, cx0, cy0, re0, im0}, {1'b1, 11'd0, 11'd0, RE_MIN, IM_MAX});
        wait_fd0();
        repeat (3) @(negedge sysclk);
        chk("restart_frame_done", fd_cnt0, 2);
        chk("restart_queues_drained", {q_iss.size() == 0, q_out.size() == 0}, 2'b11);

        // single-pixel frame on the 1x1 instance
        @(negedge sysclk); fs1 = 1'b1;
        @(negedge sysclk); fs1 = 1'b0;
        chk("one_issue", {cs1, cx1, cy1, re1, im1, busy1}, {1'b1, 11'd0, 11'd0, RE_MIN, IM_MAX, 1'b1});
        n = 0;
        while (!vld1 && n < 50) begin @(negedge sysclk); n++; end
        chk("one_pixel", {vld1, px1, py1, pd1, eol1, eof1}, {1'b1, 11'd0, 11'd0, 11'd0, 1'b1, 1'b1});
        @(negedge sysclk);
        chk("one_frame_done", {fd1, busy1, vld1}, 3'b100);
        @(negedge sysclk);
        chk("one_idle", {fd1, busy1, cs1}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
